// File: rtl/hyperbus_phy_fsm.sv
// HyperBus PHY transfer sequencer.
// Takes one linear-burst request at a time, builds the 48-bit command/address,
// and sequences chip select, the transmit clock, data/RWDS output enables and
// the receive clock gate. Write data streams from wr_*. Read data from the
// transceiver passes straight through to rd_*. The number of read words that
// have been clocked but not yet returned is limited to MaxInflight.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   tf_*                       transfer request (write flag, word address, length, one-hot CS)
//   cfg_latency_i, cfg_t_rwr_i initial latency and CS-high recovery, in clk cycles
//   wr_*                       write data stream (data, byte strobes, valid/ready)
//   rd_*                       read data stream (data, last, valid/ready)
//   cs_o, cs_ena_o             chip select vector and chip select enable
//   tx_*                       transmit clock enable, data and RWDS with output enables
//   rwds_sample_ena_o, rwds_sample_i  RWDS latency sampling during the command phase
//   rx_clk_set_o, rx_clk_reset_o, rx_*  receive clock gate and receive data stream
//   busy_o                     high whenever a transfer is in progress
module hyperbus_phy_fsm #(
  parameter int unsigned NumChips    = 2,
  parameter int unsigned MaxInflight = 6,
  parameter int unsigned LatCntWidth = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tf_valid_i,
  output logic                   tf_ready_o,
  input  logic                   tf_write_i,
  input  logic [31:0]            tf_addr_i,
  input  logic [15:0]            tf_len_i,
  input  logic [NumChips-1:0]    tf_cs_i,
  input  logic [LatCntWidth-1:0] cfg_latency_i,
  input  logic [LatCntWidth-1:0] cfg_t_rwr_i,
  input  logic [15:0]            wr_data_i,
  input  logic [1:0]             wr_strb_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [15:0]            rd_data_o,
  output logic                   rd_last_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [NumChips-1:0]    cs_o,
  output logic                   cs_ena_o,
  output logic                   tx_clk_ena_o,
  output logic [15:0]            tx_data_o,
  output logic                   tx_data_oe_o,
  output logic [1:0]             tx_rwds_o,
  output logic                   tx_rwds_oe_o,
  output logic                   rwds_sample_ena_o,
  input  logic                   rwds_sample_i,
  output logic                   rx_clk_set_o,
  output logic                   rx_clk_reset_o,
  input  logic [15:0]            rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = 16;
  localparam int unsigned LatW = LatCntWidth + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_LATENCY,
    ST_WRITE,
    ST_READ,
    ST_CS_HOLD,
    ST_RECOVERY
  } state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [31:0]            addr_q, addr_d;
  logic [CntW-1:0]        len_q, len_d;
  logic [NumChips-1:0]    cs_q, cs_d;
  logic [1:0]             cmd_cnt_q, cmd_cnt_d;
  logic [LatW-1:0]        lat_cnt_q, lat_cnt_d;
  logic                   lat_first_q, lat_first_d;
  logic [CntW-1:0]        word_cnt_q, word_cnt_d;
  logic [CntW-1:0]        iss_cnt_q, iss_cnt_d;
  logic [LatCntWidth-1:0] rec_cnt_q, rec_cnt_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [1:0]             wrwds_q, wrwds_d;

  logic [47:0]            ca_c;
  logic [LatW-1:0]        lat_rem_c;
  logic                   lat_last_c;
  logic [CntW-1:0]        inflight_c;
  logic                   rd_clk_c;
  logic                   last_word_c;

  // Command/address: read flag, linear burst, upper/lower word address split.
  assign ca_c = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};

  // RWDS sampled high during the last command cycle doubles the latency; the
  // doubling is folded in on the first latency cycle.
  assign lat_rem_c  = (lat_first_q && rwds_sample_i) ? (lat_cnt_q << 1) : lat_cnt_q;
  assign lat_last_c = (lat_rem_c <= LatW'(1));

  // Read clock runs only while the in-flight window and burst length allow.
  assign inflight_c  = iss_cnt_q - word_cnt_q;
  assign rd_clk_c    = (inflight_c < CntW'(MaxInflight)) && (iss_cnt_q < len_q);
  assign last_word_c = (word_cnt_q == (len_q - CntW'(1)));

  // State and request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cs_q        <= '0;
      cmd_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      lat_first_q <= 1'b0;
      word_cnt_q  <= '0;
      iss_cnt_q   <= '0;
      rec_cnt_q   <= '0;
      wdata_q     <= '0;
      wrwds_q     <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cs_q        <= cs_d;
      cmd_cnt_q   <= cmd_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      lat_first_q <= lat_first_d;
      word_cnt_q  <= word_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      wdata_q     <= wdata_d;
      wrwds_q     <= wrwds_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cs_d        = cs_q;
    cmd_cnt_d   = cmd_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    lat_first_d = lat_first_q;
    word_cnt_d  = word_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    wdata_d     = wdata_q;
    wrwds_d     = wrwds_q;

    tf_ready_o        = 1'b0;
    busy_o            = 1'b1;
    wr_ready_o        = 1'b0;
    rd_data_o         = '0;
    rd_last_o         = 1'b0;
    rd_valid_o        = 1'b0;
    rx_ready_o        = 1'b1;
    cs_o              = '0;
    cs_ena_o          = 1'b0;
    tx_clk_ena_o      = 1'b0;
    tx_data_o         = '0;
    tx_data_oe_o      = 1'b0;
    tx_rwds_o         = '0;
    tx_rwds_oe_o      = 1'b0;
    rwds_sample_ena_o = 1'b0;
    rx_clk_set_o      = 1'b0;
    rx_clk_reset_o    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tf_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (tf_valid_i) begin
          write_d = tf_write_i;
          addr_d  = tf_addr_i;
          len_d   = (tf_len_i == '0) ? CntW'(1) : tf_len_i;
          cs_d    = tf_cs_i;
          state_d = ST_CS_SETUP;
        end
      end

      ST_CS_SETUP: begin
        cs_o      = cs_q;
        cs_ena_o  = 1'b1;
        cmd_cnt_d = '0;
        state_d   = ST_CMD;
      end

      ST_CMD: begin
        cs_o         = cs_q;
        cs_ena_o     = 1'b1;
        tx_clk_ena_o = 1'b1;
        tx_data_oe_o = 1'b1;
        case (cmd_cnt_q)
          2'd0:    tx_data_o = ca_c[47:32];
          2'd1:    tx_data_o = ca_c[31:16];
          default: tx_data_o = ca_c[15:0];
        endcase
        if (cmd_cnt_q == 2'd2) begin
          rwds_sample_ena_o = 1'b1;
          lat_cnt_d         = LatW'(cfg_latency_i);
          lat_first_d       = 1'b1;
          state_d           = ST_LATENCY;
        end else begin
          cmd_cnt_d = cmd_cnt_q + 2'd1;
        end
      end

      ST_LATENCY: begin
        cs_o         = cs_q;
        cs_ena_o     = 1'b1;
        tx_clk_ena_o = 1'b1;
        lat_first_d  = 1'b0;
        if (write_q) begin
          tx_data_oe_o = 1'b1;
          tx_rwds_oe_o = 1'b1;
        end
        if (lat_last_c) begin
          word_cnt_d = '0;
          iss_cnt_d  = '0;
          if (write_q) begin
            wdata_d = '0;
            wrwds_d = '0;
            state_d = ST_WRITE;
          end else begin
            rx_clk_set_o = 1'b1;
            state_d      = ST_READ;
          end
        end else begin
          lat_cnt_d = lat_rem_c - LatW'(1);
        end
      end

      ST_WRITE: begin
        cs_o         = cs_q;
        cs_ena_o     = 1'b1;
        wr_ready_o   = 1'b1;
        tx_data_oe_o = 1'b1;
        tx_rwds_oe_o = 1'b1;
        // A missing beat stops the clock and holds the last driven values.
        tx_data_o    = wdata_q;
        tx_rwds_o    = wrwds_q;
        if (wr_valid_i) begin
          tx_clk_ena_o = 1'b1;
          tx_data_o    = wr_data_i;
          tx_rwds_o    = ~wr_strb_i;
          wdata_d      = wr_data_i;
          wrwds_d      = ~wr_strb_i;
          if (last_word_c) begin
            state_d = ST_CS_HOLD;
          end else begin
            word_cnt_d = word_cnt_q + CntW'(1);
          end
        end
      end

      ST_READ: begin
        cs_o         = cs_q;
        cs_ena_o     = 1'b1;
        tx_clk_ena_o = rd_clk_c;
        rd_data_o    = rx_data_i;
        rd_valid_o   = rx_valid_i;
        rx_ready_o   = rd_ready_i;
        rd_last_o    = rx_valid_i && last_word_c;
        if (rd_clk_c) begin
          iss_cnt_d = iss_cnt_q + CntW'(1);
        end
        if (rx_valid_i && rd_ready_i) begin
          if (last_word_c) begin
            state_d = ST_CS_HOLD;
          end else begin
            word_cnt_d = word_cnt_q + CntW'(1);
          end
        end
      end

      ST_CS_HOLD: begin
        cs_o           = cs_q;
        cs_ena_o       = 1'b1;
        rx_clk_reset_o = ~write_q;
        rec_cnt_d      = (cfg_t_rwr_i == '0) ? '0 : (cfg_t_rwr_i - LatCntWidth'(1));
        state_d        = ST_RECOVERY;
      end

      ST_RECOVERY: begin
        if (rec_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q - LatCntWidth'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_phy_fsm.sv
// Directed bench for hyperbus_phy_fsm with a simple transceiver model that
// returns one read word per clocked read cycle.
module tb_hyperbus_phy_fsm;

  localparam int unsigned NumChips    = 2;
  localparam int unsigned LatCntWidth = 5;

  logic                   clk_i;
  logic                   rst_ni;
  logic                   tf_valid_i;
  logic                   tf_ready_o;
  logic                   tf_write_i;
  logic [31:0]            tf_addr_i;
  logic [15:0]            tf_len_i;
  logic [NumChips-1:0]    tf_cs_i;
  logic [LatCntWidth-1:0] cfg_latency_i;
  logic [LatCntWidth-1:0] cfg_t_rwr_i;
  logic [15:0]            wr_data_i;
  logic [1:0]             wr_strb_i;
  logic                   wr_valid_i;
  logic                   wr_ready_o;
  logic [15:0]            rd_data_o;
  logic                   rd_last_o;
  logic                   rd_valid_o;
  logic                   rd_ready_i;
  logic [NumChips-1:0]    cs_o;
  logic                   cs_ena_o;
  logic                   tx_clk_ena_o;
  logic [15:0]            tx_data_o;
  logic                   tx_data_oe_o;
  logic [1:0]             tx_rwds_o;
  logic                   tx_rwds_oe_o;
  logic                   rwds_sample_ena_o;
  logic                   rwds_sample_i;
  logic                   rx_clk_set_o;
  logic                   rx_clk_reset_o;
  logic [15:0]            rx_data_i;
  logic                   rx_valid_i;
  logic                   rx_ready_o;
  logic                   busy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Observations recorded by run_xfer.
  logic        o_setup_ok, o_cmd_ok, o_lat_rwds_ok, o_hold, o_timeout;
  logic [15:0] o_ca [3];
  logic [2:0]  o_samp;
  int          o_lat, o_beats, o_last_idx, o_last_cnt, o_bad;
  int          o_stall, o_stall_bad, o_issue_pre, o_rec, o_rec_bad;
  logic [15:0] o_tx_data [8];
  logic [1:0]  o_tx_rwds [8];

  // Write stimulus tables.
  logic [15:0] w_data [8];
  logic [1:0]  w_strb [8];
  logic        w_sched [16];

  // Transceiver model state.
  logic [15:0] rxq [$];
  logic        rd_phase;
  logic [15:0] push_idx;

  hyperbus_phy_fsm #(
    .NumChips(NumChips), .MaxInflight(6), .LatCntWidth(LatCntWidth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tf_valid_i(tf_valid_i), .tf_ready_o(tf_ready_o), .tf_write_i(tf_write_i),
    .tf_addr_i(tf_addr_i), .tf_len_i(tf_len_i), .tf_cs_i(tf_cs_i),
    .cfg_latency_i(cfg_latency_i), .cfg_t_rwr_i(cfg_t_rwr_i),
    .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .cs_o(cs_o), .cs_ena_o(cs_ena_o), .tx_clk_ena_o(tx_clk_ena_o),
    .tx_data_o(tx_data_o), .tx_data_oe_o(tx_data_oe_o),
    .tx_rwds_o(tx_rwds_o), .tx_rwds_oe_o(tx_rwds_oe_o),
    .rwds_sample_ena_o(rwds_sample_ena_o), .rwds_sample_i(rwds_sample_i),
    .rx_clk_set_o(rx_clk_set_o), .rx_clk_reset_o(rx_clk_reset_o),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Transceiver: each clocked read cycle returns word 0xC000+n one cycle later.
  initial begin
    logic pop, push;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    rd_phase   = 1'b0;
    push_idx   = '0;
    forever begin
      @(negedge clk_i);
      #2;
      pop  = rx_valid_i && rx_ready_o;
      push = tx_clk_ena_o && rd_phase;
      if (rx_clk_set_o) begin
        rd_phase = 1'b1;
        push_idx = '0;
      end
      if (rx_clk_reset_o) rd_phase = 1'b0;
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        rxq.delete();
        rd_phase = 1'b0;
      end else begin
        if (pop && rxq.size() > 0) void'(rxq.pop_front());
        if (push) begin
          rxq.push_back(16'hC000 + push_idx);
          push_idx = push_idx + 16'd1;
        end
      end
      rx_valid_i = (rxq.size() > 0);
      rx_data_i  = (rxq.size() > 0) ? rxq[0] : 16'h0000;
    end
  end

  // Drives one transfer from IDLE back to IDLE and records what was seen.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                          input logic [NumChips-1:0] cs, input int lat, input int trwr,
                          input logic rwds, input int rd_hold);
    int wcyc, wbeat, rcyc, guard;
    o_setup_ok = 0; o_cmd_ok = 1; o_lat_rwds_ok = 1; o_hold = 0; o_timeout = 0;
    o_samp = '0; o_lat = 0; o_beats = 0; o_last_idx = -1; o_last_cnt = 0; o_bad = 0;
    o_stall = 0; o_stall_bad = 0; o_issue_pre = 0; o_rec = 0; o_rec_bad = 0;
    for (int i = 0; i < 3; i++) o_ca[i] = '0;
    cfg_latency_i = LatCntWidth'(lat);
    cfg_t_rwr_i   = LatCntWidth'(trwr);
    rwds_sample_i = rwds;
    @(negedge clk_i);
    guard = 0;
    while (!tf_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    tf_valid_i = 1'b1; tf_write_i = wr; tf_addr_i = addr; tf_len_i = len; tf_cs_i = cs;
    @(negedge clk_i);
    tf_valid_i = 1'b0;
    #1;
    o_setup_ok = cs_ena_o && !tx_clk_ena_o && (cs_o == cs) && busy_o && !tf_ready_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      o_ca[i]   = tx_data_o;
      o_samp[i] = rwds_sample_ena_o;
      if (!(tx_clk_ena_o && tx_data_oe_o && cs_ena_o)) o_cmd_ok = 0;
    end
    guard = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (wr && wr_ready_o) break;
      o_lat++;
      if (!tx_clk_ena_o) o_lat_rwds_ok = 0;
      if (wr && !(tx_rwds_oe_o && tx_rwds_o == 2'b00 && tx_data_oe_o)) o_lat_rwds_ok = 0;
      if (!wr && rx_clk_set_o) break;
      guard++;
      if (guard > 200) begin o_timeout = 1; break; end
    end
    if (wr) begin
      wcyc = 0; wbeat = 0;
      while (wr_ready_o && wcyc < 64) begin
        wr_valid_i = (wcyc < 16) ? w_sched[wcyc] : 1'b1;
        wr_data_i  = w_data[wbeat % 8];
        wr_strb_i  = w_strb[wbeat % 8];
        #1;
        if (wr_valid_i) begin
          o_tx_data[wbeat % 8] = tx_data_o;
          o_tx_rwds[wbeat % 8] = tx_rwds_o;
          if (!tx_clk_ena_o) o_bad++;
          wbeat++;
        end else begin
          o_stall++;
          if (tx_clk_ena_o || !tx_data_oe_o) o_stall_bad++;
          if (wbeat > 0 && (tx_data_o != o_tx_data[(wbeat-1) % 8] ||
                            tx_rwds_o != o_tx_rwds[(wbeat-1) % 8])) o_stall_bad++;
        end
        wcyc++;
        @(negedge clk_i);
      end
      if (wcyc >= 64) o_timeout = 1;
      wr_valid_i = 1'b0;
      o_beats = wbeat;
      #1;
      o_hold = cs_ena_o && !tx_clk_ena_o && !wr_ready_o && !rx_clk_reset_o;
    end else begin
      rcyc = 0;
      forever begin
        @(negedge clk_i);
        rd_ready_i = (rcyc >= rd_hold);
        #1;
        if (rx_clk_reset_o) begin
          o_hold = cs_ena_o && !tx_clk_ena_o;
          break;
        end
        if (tx_clk_ena_o && o_beats == 0) o_issue_pre++;
        if (rd_valid_o && rd_ready_i) begin
          if (rd_data_o != 16'hC000 + 16'(o_beats)) o_bad++;
          if (rd_last_o) begin
            o_last_idx = o_beats;
            o_last_cnt++;
          end
          o_beats++;
        end
        rcyc++;
        if (rcyc > 400) begin o_timeout = 1; break; end
      end
      rd_ready_i = 1'b1;
    end
    guard = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (tf_ready_o) break;
      o_rec++;
      if (cs_ena_o || !busy_o) o_rec_bad++;
      guard++;
      if (guard > 100) begin o_timeout = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tf_valid_i = 0; tf_write_i = 0; tf_addr_i = '0; tf_len_i = '0; tf_cs_i = '0;
    cfg_latency_i = '0; cfg_t_rwr_i = '0; wr_data_i = '0; wr_strb_i = '0; wr_valid_i = 0;
    rd_ready_i = 1'b1; rwds_sample_i = 0;
    for (int i = 0; i < 16; i++) w_sched[i] = 1'b1;
    #3;
    n_checks++;
    if (tf_ready_o !== 1'b1 || rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: tf_ready=%b rx_ready=%b busy=%b expected 1 1 0", tf_ready_o, rx_ready_o, busy_o);
    end
    n_checks++;
    if ({cs_ena_o, tx_clk_ena_o, tx_data_oe_o, tx_rwds_oe_o, wr_ready_o, rd_valid_o, rd_last_o,
         rwds_sample_ena_o, rx_clk_set_o, rx_clk_reset_o} !== 10'd0 || cs_o !== 2'b00 ||
        tx_data_o !== 16'h0 || tx_rwds_o !== 2'b00 || rd_data_o !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: cs_ena=%b clk=%b doe=%b cs=%b tx_data=%h expected all 0", cs_ena_o, tx_clk_ena_o, tx_data_oe_o, cs_o, tx_data_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (tf_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_idle: tf_ready=%b busy=%b expected 1 0", tf_ready_o, busy_o);
    end
  endtask

  task automatic test_read_basic();
    run_xfer(1'b0, 32'h0000_0100, 16'd4, 2'b01, 6, 3, 1'b0, 0);
    n_checks++;
    if (o_timeout !== 1'b0 || o_setup_ok !== 1'b1 || o_cmd_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_basic_seq: timeout=%b setup=%b cmd=%b expected 0 1 1", o_timeout, o_setup_ok, o_cmd_ok);
    end
    n_checks++;
    if (o_ca[0] !== 16'hA000 || o_ca[1] !== 16'h0020 || o_ca[2] !== 16'h0000) begin
      n_errors++;
      $display("FAIL rd_basic_ca: got %h %h %h expected a000 0020 0000", o_ca[0], o_ca[1], o_ca[2]);
    end
    n_checks++;
    if (o_samp !== 3'b100) begin
      n_errors++;
      $display("FAIL rd_basic_sample: got %b expected 100", o_samp);
    end
    n_checks++;
    if (o_lat != 6 || o_lat_rwds_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_basic_latency: got %0d cycles clk_ok=%b expected 6 1", o_lat, o_lat_rwds_ok);
    end
    n_checks++;
    if (o_beats != 4 || o_bad != 0 || o_last_idx != 3 || o_last_cnt != 1) begin
      n_errors++;
      $display("FAIL rd_basic_beats: beats=%0d bad=%0d last_idx=%0d last_cnt=%0d expected 4 0 3 1", o_beats, o_bad, o_last_idx, o_last_cnt);
    end
    n_checks++;
    if (o_hold !== 1'b1 || o_rec != 3 || o_rec_bad != 0) begin
      n_errors++;
      $display("FAIL rd_basic_hold_rec: hold=%b rec=%0d rec_bad=%0d expected 1 3 0", o_hold, o_rec, o_rec_bad);
    end
    n_checks++;
    if (cs_o !== 2'b00 || cs_ena_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_basic_idle_cs: cs=%b cs_ena=%b expected 00 0", cs_o, cs_ena_o);
    end
  endtask

  task automatic test_read_double_latency();
    run_xfer(1'b0, 32'h0000_0100, 16'd4, 2'b01, 6, 3, 1'b1, 0);
    n_checks++;
    if (o_lat != 12 || o_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_double_latency: got %0d cycles timeout=%b expected 12 0", o_lat, o_timeout);
    end
    n_checks++;
    if (o_beats != 4 || o_bad != 0 || o_last_idx != 3) begin
      n_errors++;
      $display("FAIL rd_double_beats: beats=%0d bad=%0d last_idx=%0d expected 4 0 3", o_beats, o_bad, o_last_idx);
    end
    rwds_sample_i = 1'b0;
  endtask

  task automatic test_write_strobe_gap();
    w_data[0] = 16'h1111; w_data[1] = 16'h2222; w_data[2] = 16'h3333;
    w_strb[0] = 2'b11;    w_strb[1] = 2'b01;    w_strb[2] = 2'b11;
    w_sched[0] = 1; w_sched[1] = 1; w_sched[2] = 0; w_sched[3] = 0; w_sched[4] = 1;
    run_xfer(1'b1, 32'h0000_1235, 16'd3, 2'b10, 4, 2, 1'b0, 0);
    for (int i = 0; i < 16; i++) w_sched[i] = 1'b1;
    n_checks++;
    if (o_ca[0] !== 16'h2000 || o_ca[1] !== 16'h0246 || o_ca[2] !== 16'h0005 || o_setup_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_ca: got %h %h %h setup=%b expected 2000 0246 0005 1", o_ca[0], o_ca[1], o_ca[2], o_setup_ok);
    end
    n_checks++;
    if (o_lat != 4 || o_lat_rwds_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_latency: got %0d cycles rwds_ok=%b expected 4 1", o_lat, o_lat_rwds_ok);
    end
    n_checks++;
    if (o_beats != 3 || o_bad != 0 || o_tx_data[0] !== 16'h1111 || o_tx_data[1] !== 16'h2222 || o_tx_data[2] !== 16'h3333) begin
      n_errors++;
      $display("FAIL wr_data: beats=%0d bad=%0d data %h %h %h expected 3 0 1111 2222 3333", o_beats, o_bad, o_tx_data[0], o_tx_data[1], o_tx_data[2]);
    end
    n_checks++;
    if (o_tx_rwds[0] !== 2'b00 || o_tx_rwds[1] !== 2'b10 || o_tx_rwds[2] !== 2'b00) begin
      n_errors++;
      $display("FAIL wr_rwds: got %b %b %b expected 00 10 00", o_tx_rwds[0], o_tx_rwds[1], o_tx_rwds[2]);
    end
    n_checks++;
    if (o_stall != 2 || o_stall_bad != 0) begin
      n_errors++;
      $display("FAIL wr_gap_stall: stall=%0d stall_bad=%0d expected 2 0", o_stall, o_stall_bad);
    end
    n_checks++;
    if (o_hold !== 1'b1 || o_rec != 2 || o_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_hold_rec: hold=%b rec=%0d timeout=%b expected 1 2 0", o_hold, o_rec, o_timeout);
    end
  endtask

  task automatic test_backpressure();
    run_xfer(1'b0, 32'h0000_0040, 16'd10, 2'b01, 2, 1, 1'b0, 20);
    n_checks++;
    if (o_issue_pre != 6) begin
      n_errors++;
      $display("FAIL bp_inflight_cap: issued %0d before first accept expected 6", o_issue_pre);
    end
    n_checks++;
    if (o_beats != 10 || o_bad != 0 || o_last_idx != 9 || o_last_cnt != 1 || o_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_beats: beats=%0d bad=%0d last_idx=%0d last_cnt=%0d timeout=%b expected 10 0 9 1 0", o_beats, o_bad, o_last_idx, o_last_cnt, o_timeout);
    end
    n_checks++;
    if (o_rec != 1 || o_hold !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_rec: rec=%0d hold=%b expected 1 1", o_rec, o_hold);
    end
  endtask

  task automatic test_len_zero_boundaries();
    run_xfer(1'b0, 32'h0000_0008, 16'd0, 2'b10, 0, 0, 1'b0, 0);
    n_checks++;
    if (o_ca[1] !== 16'h0001 || o_lat != 1) begin
      n_errors++;
      $display("FAIL zero_latency: ca1=%h lat=%0d expected 0001 1", o_ca[1], o_lat);
    end
    n_checks++;
    if (o_beats != 1 || o_last_idx != 0 || o_bad != 0 || o_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_len_beats: beats=%0d last_idx=%0d bad=%0d timeout=%b expected 1 0 0 0", o_beats, o_last_idx, o_bad, o_timeout);
    end
    n_checks++;
    if (o_rec != 1) begin
      n_errors++;
      $display("FAIL zero_trwr_rec: rec=%0d expected 1", o_rec);
    end
  endtask

  task automatic test_reset_mid_write();
    int guard;
    cfg_latency_i = 5'd2; cfg_t_rwr_i = 5'd1;
    @(negedge clk_i);
    tf_valid_i = 1'b1; tf_write_i = 1'b1; tf_addr_i = 32'h0000_0300; tf_len_i = 16'd5; tf_cs_i = 2'b01;
    @(negedge clk_i);
    tf_valid_i = 1'b0;
    guard = 0;
    while (!wr_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    for (int i = 0; i < 2; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 16'h5A00 + 16'(i); wr_strb_i = 2'b11;
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (guard >= 50 || tf_ready_o !== 1'b1 || cs_ena_o !== 1'b0 || busy_o !== 1'b0 ||
        wr_ready_o !== 1'b0 || tx_clk_ena_o !== 1'b0 || cs_o !== 2'b00) begin
      n_errors++;
      $display("FAIL rst_mid_wr_async: guard=%0d tf_ready=%b cs_ena=%b busy=%b wr_ready=%b expected <50 1 0 0 0", guard, tf_ready_o, cs_ena_o, busy_o, wr_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (tf_ready_o !== 1'b1 || cs_ena_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_wr_idle: tf_ready=%b cs_ena=%b busy=%b expected 1 0 0", tf_ready_o, cs_ena_o, busy_o);
    end
    run_xfer(1'b0, 32'h0000_0200, 16'd2, 2'b01, 3, 1, 1'b0, 0);
    n_checks++;
    if (o_ca[0] !== 16'hA000 || o_ca[1] !== 16'h0040 || o_lat != 3) begin
      n_errors++;
      $display("FAIL rst_then_read_cmd: ca0=%h ca1=%h lat=%0d expected a000 0040 3", o_ca[0], o_ca[1], o_lat);
    end
    n_checks++;
    if (o_beats != 2 || o_bad != 0 || o_last_idx != 1 || o_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_then_read_beats: beats=%0d bad=%0d last_idx=%0d timeout=%b expected 2 0 1 0", o_beats, o_bad, o_last_idx, o_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_double_latency();
    test_write_strobe_gap();
    test_backpressure();
    test_len_zero_boundaries();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hyperbus_phy_fsm.md
HYPERBUS_PHY_FSM -- requirements
Module: hyperbus_phy_fsm

Interface
REQ-001 SHALL have parameter NumChips, default 2, number of chip selects.
REQ-002 SHALL have parameter MaxInflight, default 6, max read words clocked but not yet returned by the transceiver.
REQ-003 SHALL have parameter LatCntWidth, default 5, width of latency and recovery counters.
REQ-004 SHALL have ports, clock and reset first:
- clk_i  in  1  system/PHY clock.
- rst_ni  in  1  reset; one clock; asynchronous, active-low.
- tf_valid_i / tf_ready_o  in/out  1  transfer request handshake.
- tf_write_i  in  1  1 = write, 0 = read.
- tf_addr_i  in  32  word address.
- tf_len_i  in  16  burst length in 16-bit words; 0 is treated as 1.
- tf_cs_i  in  NumChips  one-hot chip select.
- cfg_latency_i  in  LatCntWidth  initial latency in clk cycles.
- cfg_t_rwr_i  in  LatCntWidth  recovery cycles with CS high.
- wr_data_i  in  16.
- wr_strb_i  in  2.
- wr_valid_i / wr_ready_o  in/out  1  write data handshake.
- rd_data_o  out  16.
- rd_last_o  out  1.
- rd_valid_o / rd_ready_i  out/in  1  read data handshake.
- cs_o  out  NumChips.
- cs_ena_o  out  1.
- tx_clk_ena_o  out  1.
- tx_data_o  out  16.
- tx_data_oe_o  out  1.
- tx_rwds_o  out  2.
- tx_rwds_oe_o  out  1.
- rwds_sample_ena_o  out  1.
- rwds_sample_i  in  1.
- rx_clk_set_o / rx_clk_reset_o  out  1.
- rx_data_i  in  16.
- rx_valid_i / rx_ready_o  in/out  1.
- busy_o  out  1.

Function
REQ-005 SHALL implement states IDLE, CS_SETUP, CMD (3 cycles), LATENCY, WRITE, READ, CS_HOLD, RECOVERY.
REQ-006 IDLE: tf_ready_o=1; on tf_valid_i register the request and enter CS_SETUP.
REQ-007 CS_SETUP: asserts cs_ena_o for 1 cycle with tx_clk_ena_o=0; next state CMD.
REQ-008 CMD: tx_clk_ena_o=1 and tx_data_oe_o=1 for 3 cycles, driving CA[47:32], CA[31:16], CA[15:0] in that order.
- CA[47]=~write, CA[46]=0, CA[45]=1 (linear).
- CA[44:16]=addr[31:3], CA[15:3]=0, CA[2:0]=addr[2:0].
REQ-009 During the 3rd CMD cycle, rwds_sample_ena_o=1; latency target = cfg_latency_i, doubled when rwds_sample_i=1 one cycle later.
REQ-010 Latency counter SHALL be LatCntWidth+1 bits wide (no overflow on doubling). cfg_latency_i=0 makes LATENCY last 1 cycle.
REQ-011 LATENCY: tx_clk_ena_o=1, counts down to 0.
- Write: tx_rwds_oe_o=1 with tx_rwds_o=0, and tx_data_oe_o=1 during LATENCY.
- Read: rx_clk_set_o pulses on the last LATENCY cycle.
REQ-012 WRITE: each wr_valid_i&wr_ready_o beat drives tx_data_o=wr_data_i and tx_rwds_o=~wr_strb_i, with tx_clk_ena_o=1 that cycle.
- wr_ready_o=1 only in WRITE.
- wr_valid_i=0 SHALL stall with tx_clk_ena_o=0 and outputs held.
REQ-013 READ: tx_clk_ena_o=1 while issued-minus-received < MaxInflight and issued < len; otherwise 0 (clock stop).
REQ-014 READ: rd_data_o=rx_data_i, rd_valid_o=rx_valid_i, rx_ready_o=rd_ready_i (combinational pass-through).
- rd_last_o=1 on the len-th accepted word.
- Outside READ: rx_ready_o=1, rd_valid_o=0.
REQ-015 After the final write beat, or the final read word accepted, SHALL enter CS_HOLD.
- CS_HOLD: cs_ena_o=1 with tx_clk_ena_o=0 for 1 cycle.
- Read: rx_clk_reset_o pulses in CS_HOLD.
REQ-016 RECOVERY: cs_ena_o=0 for max(cfg_t_rwr_i,1) cycles, then IDLE.
REQ-017 Word and in-flight counters SHALL be 16 bits, no wrap.
- tf_len_i=16'hFFFF SHALL transfer exactly 65535 words.
REQ-018 tf_ready_o=0 and busy_o=1 in all states except IDLE.
REQ-019 cs_o SHALL hold the registered tf_cs_i from CS_SETUP through CS_HOLD, else 0.

Reset
REQ-020 On rst_ni low SHALL, asynchronously:
- enter IDLE;
- set all outputs 0 except tf_ready_o=1 and rx_ready_o=1;
- clear counters and the registered request.
REQ-021 Reset mid-transfer SHALL abort without completing the burst. Only rst_ni recovers the block.

Verification
- Read, addr 0x100, len 4, latency 6, rwds_sample_i=0 -> CA words 0xA000, 0x0020, 0x0000; 6 LATENCY cycles; 4 rd beats, rd_last_o on 4th; rx_clk_reset_o pulse; t_rwr cycles of CS high.
- Same read with rwds_sample_i=1 -> 12 LATENCY cycles.
- Write len 3, strb 2'b01 on beat 2 -> tx_rwds_o=2'b10 on beat 2; wr_valid_i gap of 2 cycles -> tx_clk_ena_o low 2 cycles.
- Read with rd_ready_i=0 for 20 cycles -> tx_clk_ena_o drops once 6 words are in flight; no word lost; resumes when rd_ready_i=1.
- tf_len_i=0 -> exactly 1 word; cfg_latency_i=0 -> 1 LATENCY cycle; cfg_t_rwr_i=0 -> 1 recovery cycle.
- rst_ni low mid-WRITE -> next cycle IDLE, cs_ena_o=0, tf_ready_o=1; a new read completes correctly.
